stall_fwd_unit: RTL and testbench
=================================

STALL_FWD_UNIT -- requirements
Module: stall_fwd_unit

Interface
REQ-001 Parameter CNT_W, default 16, sets the width of the stall performance counter.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 rs_D, rt_D  input  5 each  source register fields of the instruction in D.
REQ-005 wa_D  input  5  destination register of the D instruction; 0 when it writes nothing.
REQ-006 Tuse_RS0, Tuse_RS1, Tuse_RT0, Tuse_RT1, Tuse_RT2  input  1 each  operand-use flags from the D-stage T-code decoder; RSn/RTn means the operand is needed n stages after D.
REQ-007 Tnew_D  input  2  result latency of the D instruction: 0=T_PC, 1=T_ALU, 2=T_DM.
REQ-008 xalu_D  input  1  D instruction is a mult/div/HI-LO class instruction.
REQ-009 xalu_busy  input  1  the multiply/divide unit is computing.
REQ-010 stall  output  1  freeze F/D and insert a bubble into E.
REQ-011 fwd_rs_D, fwd_rt_D  output  2 each  D-stage operand source: 0=regfile, 1=E, 2=M, 3=W.
REQ-012 fwd_rs_E, fwd_rt_E  output  2 each  E-stage operand source: 0=pipeline register, 2=M, 3=W.
REQ-013 fwd_rt_M  output  2  M-stage store-data source: 0=pipeline register, 3=W.
REQ-014 stall_cnt  output  CNT_W  count of cycles with stall=1.

Function
REQ-015 The unit shall hold a tracking pipeline of stage records E, M and W.
- E and M records: rs, rt, wa, Tnew, xalu.
- W record: wa only.
REQ-016 When stall=0, each rising edge shall perform these transfers:
- E record <= {rs_D, rt_D, wa_D, Tnew_D, xalu_D}.
- M record <= E record, with Tnew_M <= (Tnew_E==0 ? 0 : Tnew_E-1).
- wa_W <= wa_M.
REQ-017 When stall=1, the E record shall load a bubble (wa=0, Tnew=0, xalu=0, rs=0, rt=0) while M and W still advance as in REQ-016.
REQ-018 The stall shall be derived from the operand use times, combinationally from the current D inputs and the registered E/M records.
- Tuse_rs = 0 if Tuse_RS0, 1 if Tuse_RS1, otherwise the operand is unused.
- Tuse_rt = 0 if Tuse_RT0, 1 if Tuse_RT1, 2 if Tuse_RT2, otherwise the operand is unused.
REQ-019 stall shall be 1 when any of the following holds:
- a used rs_D (nonzero) equals wa_E with Tnew_E > Tuse_rs;
- a used rs_D (nonzero) equals wa_M with Tnew_M > Tuse_rs;
- the same two conditions hold for rt_D against Tuse_rt;
- xalu_D=1 and (xalu_busy=1 or xalu_E=1).
REQ-020 Register 0 shall never cause a stall or a forward.
REQ-021 Each forward selector shall pick the nearest younger stage whose wa matches the nonzero source register.
- Priority is E, then M, then W.
- A stage is a valid source only when its Tnew is 0; W is always valid.
- If the nearest matching stage has Tnew>0, the selector shall output 0; that case is covered by stall.
REQ-022 fwd_rs_D and fwd_rt_D shall compare against E, M and W.
REQ-023 fwd_rs_E and fwd_rt_E shall use rs_E and rt_E and compare against M and W only.
REQ-024 fwd_rt_M shall use rt_M and compare against W only.
REQ-025 All outputs except stall_cnt shall be combinational from the inputs and the registered state; there are no other outputs.
REQ-026 stall_cnt shall increment by 1 on each rising edge where stall=1 and shall saturate at all-ones.

Reset
REQ-027 While reset=1 at a rising edge, all stage records shall clear to 0 and stall_cnt shall clear to 0.
REQ-028 While reset=1, stall shall be driven 0 and all forward selectors shall be driven 0.
REQ-029 A reset asserted mid-stall shall discard the pending hazard; the first cycle after reset shall show stall=0 unless the current D inputs hazard against the cleared records (which is impossible).

Verification
REQ-030 Load-use: lw into $8 in D (Tnew_D=2), then addu with rs_D=8 and Tuse_RS1 -> stall=1 for 1 cycle, then fwd_rs_E=3 on the cycle the addu reaches E.
REQ-031 Branch after ALU: addu into $9, then beq with rs_D=9 and Tuse_RS0 -> stall=1 for 1 cycle, then fwd_rs_D=2.
REQ-032 Store after load: lw into $4, then sw with rt_D=4 and Tuse_RT2 -> stall=0; fwd_rt_M=3 when the sw reaches M.
REQ-033 Register zero: wa_D=0 with Tnew_D=2, then a reader with rs_D=0 -> stall=0 and all forward selectors=0.
REQ-034 XALU: xalu_busy=1 and xalu_D=1 for 5 cycles -> stall=1 for those 5 cycles and stall_cnt increments by 5; stall drops the cycle xalu_busy falls.
REQ-035 Reset and saturation: with CNT_W=4, hold a hazard for 20 cycles -> stall_cnt stops at 15; assert reset for 1 cycle -> stall_cnt=0 and stall=0.

Source files
------------

// File: rtl/stall_fwd_unit.sv
// Hazard unit for a 5-stage pipeline: tracks E/M/W destination records, raises
// stall on use-before-ready hazards and picks the forwarding source per operand.
module stall_fwd_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_D,
    input  logic [4:0]       rt_D,
    input  logic [4:0]       wa_D,
    input  logic             Tuse_RS0,
    input  logic             Tuse_RS1,
    input  logic             Tuse_RT0,
    input  logic             Tuse_RT1,
    input  logic             Tuse_RT2,
    input  logic [1:0]       Tnew_D,
    input  logic             xalu_D,
    input  logic             xalu_busy,
    output logic             stall,
    output logic [1:0]       fwd_rs_D,
    output logic [1:0]       fwd_rt_D,
    output logic [1:0]       fwd_rs_E,
    output logic [1:0]       fwd_rt_E,
    output logic [1:0]       fwd_rt_M,
    output logic [CNT_W-1:0] stall_cnt
);

    logic [4:0] rs_e, rt_e, wa_e;
    logic [1:0] tnew_e;
    logic       xalu_e;
    logic [4:0] rt_m, wa_m;
    logic [1:0] tnew_m;
    logic [4:0] wa_w;

    logic       rs_used, rt_used;
    logic [1:0] tuse_rs, tuse_rt;
    logic       hz_rs, hz_rt, hz_xalu, stall_raw;

    // Nearest matching stage wins; a match that is not yet ready yields 0.
    function automatic logic [1:0] pick_emw(
        input logic [4:0] src,
        input logic [4:0] we, input logic [1:0] te,
        input logic [4:0] wm, input logic [1:0] tm,
        input logic [4:0] ww
    );
        logic [1:0] sel;
        sel = 2'd0;
        if (src != 5'd0) begin
            if (we == src)      sel = (te == 2'd0) ? 2'd1 : 2'd0;
            else if (wm == src) sel = (tm == 2'd0) ? 2'd2 : 2'd0;
            else if (ww == src) sel = 2'd3;
        end
        return sel;
    endfunction

    always_comb begin
        rs_used = Tuse_RS0 | Tuse_RS1;
        rt_used = Tuse_RT0 | Tuse_RT1 | Tuse_RT2;
        tuse_rs = Tuse_RS0 ? 2'd0 : 2'd1;
        tuse_rt = Tuse_RT0 ? 2'd0 : (Tuse_RT1 ? 2'd1 : 2'd2);

        hz_rs = rs_used && (rs_D != 5'd0) &&
                (((rs_D == wa_e) && (tnew_e > tuse_rs)) ||
                 ((rs_D == wa_m) && (tnew_m > tuse_rs)));
        hz_rt = rt_used && (rt_D != 5'd0) &&
                (((rt_D == wa_e) && (tnew_e > tuse_rt)) ||
                 ((rt_D == wa_m) && (tnew_m > tuse_rt)));
        hz_xalu   = xalu_D && (xalu_busy || xalu_e);
        stall_raw = hz_rs || hz_rt || hz_xalu;

        stall    = 1'b0;
        fwd_rs_D = 2'd0;
        fwd_rt_D = 2'd0;
        fwd_rs_E = 2'd0;
        fwd_rt_E = 2'd0;
        fwd_rt_M = 2'd0;
        if (!reset) begin
            stall    = stall_raw;
            fwd_rs_D = pick_emw(rs_D, wa_e, tnew_e, wa_m, tnew_m, wa_w);
            fwd_rt_D = pick_emw(rt_D, wa_e, tnew_e, wa_m, tnew_m, wa_w);
            // Later stages see no E match: pass a zero destination for that slot.
            fwd_rs_E = pick_emw(rs_e, 5'd0, 2'd0, wa_m, tnew_m, wa_w);
            fwd_rt_E = pick_emw(rt_e, 5'd0, 2'd0, wa_m, tnew_m, wa_w);
            fwd_rt_M = pick_emw(rt_m, 5'd0, 2'd0, 5'd0, 2'd0, wa_w);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rs_e      <= 5'd0;
            rt_e      <= 5'd0;
            wa_e      <= 5'd0;
            tnew_e    <= 2'd0;
            xalu_e    <= 1'b0;
            rt_m      <= 5'd0;
            wa_m      <= 5'd0;
            tnew_m    <= 2'd0;
            wa_w      <= 5'd0;
            stall_cnt <= '0;
        end else begin
            rt_m   <= rt_e;
            wa_m   <= wa_e;
            tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
            wa_w   <= wa_m;
            if (stall_raw) begin
                rs_e   <= 5'd0;
                rt_e   <= 5'd0;
                wa_e   <= 5'd0;
                tnew_e <= 2'd0;
                xalu_e <= 1'b0;
            end else begin
                rs_e   <= rs_D;
                rt_e   <= rt_D;
                wa_e   <= wa_D;
                tnew_e <= Tnew_D;
                xalu_e <= xalu_D;
            end
            if (stall_raw && (stall_cnt != {CNT_W{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_stall_fwd_unit.sv
// Directed scenarios followed by random traffic, all compared against a
// queue-style pipeline model of the hazard/forward rules.
module tb_stall_fwd_unit;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int UNUSED = 99;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [4:0] rs_D = '0, rt_D = '0, wa_D = '0;
    logic Tuse_RS0 = 0, Tuse_RS1 = 0, Tuse_RT0 = 0, Tuse_RT1 = 0, Tuse_RT2 = 0;
    logic [1:0] Tnew_D = '0;
    logic xalu_D = 0, xalu_busy = 0;
    logic stall;
    logic [1:0] fwd_rs_D, fwd_rt_D, fwd_rs_E, fwd_rt_E, fwd_rt_M;
    logic [CNT_W-1:0] stall_cnt;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int rs, rt, wa, tnew;
        bit xalu;
    } rec_t;

    rec_t pipe[3];      // 0=E, 1=M, 2=W
    int   cnt_exp = 0;
    bit   stall_exp;

    stall_fwd_unit #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .rs_D(rs_D), .rt_D(rt_D), .wa_D(wa_D),
        .Tuse_RS0(Tuse_RS0), .Tuse_RS1(Tuse_RS1),
        .Tuse_RT0(Tuse_RT0), .Tuse_RT1(Tuse_RT1), .Tuse_RT2(Tuse_RT2),
        .Tnew_D(Tnew_D), .xalu_D(xalu_D), .xalu_busy(xalu_busy),
        .stall(stall),
        .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
        .fwd_rs_E(fwd_rs_E), .fwd_rt_E(fwd_rt_E), .fwd_rt_M(fwd_rt_M),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int use_rs();
        if (Tuse_RS0) return 0;
        if (Tuse_RS1) return 1;
        return UNUSED;
    endfunction

    function automatic int use_rt();
        if (Tuse_RT0) return 0;
        if (Tuse_RT1) return 1;
        if (Tuse_RT2) return 2;
        return UNUSED;
    endfunction

    function automatic bit hazard(input int src, input int tuse);
        if (src == 0 || tuse == UNUSED) return 0;
        for (int i = 0; i < 2; i++)
            if (pipe[i].wa == src && pipe[i].tnew > tuse) return 1;
        return 0;
    endfunction

    // Stage i encodes as i+1 (E=1, M=2, W=3); the nearest match decides.
    function automatic int fwd_model(input int src, input int first);
        if (reset || src == 0) return 0;
        for (int i = first; i < 3; i++)
            if (pipe[i].wa == src) return (pipe[i].tnew == 0) ? i + 1 : 0;
        return 0;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) pipe[i] = '{0, 0, 0, 0, 0};
        cnt_exp = 0;
    endtask

    task automatic settle();
        bit raw;
        #1;
        raw = hazard(rs_D, use_rs()) || hazard(rt_D, use_rt()) ||
              (xalu_D && (xalu_busy || pipe[0].xalu));
        stall_exp = !reset && raw;
        check("stall", stall, stall_exp);
        check("fwd_rs_D", fwd_rs_D, fwd_model(rs_D, 0));
        check("fwd_rt_D", fwd_rt_D, fwd_model(rt_D, 0));
        check("fwd_rs_E", fwd_rs_E, fwd_model(pipe[0].rs, 1));
        check("fwd_rt_E", fwd_rt_E, fwd_model(pipe[0].rt, 1));
        check("fwd_rt_M", fwd_rt_M, fwd_model(pipe[1].rt, 2));
        check("stall_cnt", stall_cnt, cnt_exp);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) begin
            clear_model();
        end else begin
            pipe[2].wa = pipe[1].wa;
            pipe[1] = pipe[0];
            pipe[1].tnew = (pipe[0].tnew > 0) ? pipe[0].tnew - 1 : 0;
            if (stall_exp) pipe[0] = '{0, 0, 0, 0, 0};
            else pipe[0] = '{rs_D, rt_D, wa_D, Tnew_D, xalu_D};
            if (stall_exp && cnt_exp < CNT_MAX) cnt_exp++;
        end
        #1;
    endtask

    // tu = {RT2, RT1, RT0, RS1, RS0}
    task automatic set_d(input int rs, input int rt, input int wa,
                         input logic [4:0] tu, input int tnew, input bit x);
        rs_D = 5'(rs); rt_D = 5'(rt); wa_D = 5'(wa);
        {Tuse_RT2, Tuse_RT1, Tuse_RT0, Tuse_RS1, Tuse_RS0} = tu;
        Tnew_D = 2'(tnew); xalu_D = x;
    endtask

    initial begin
        clear_model();
        tick();
        settle();
        check("reset_stall", stall, 0);
        check("reset_fwd", fwd_rs_D, 0);
        tick();
        settle();
        check("reset_cnt", stall_cnt, 0);
        reset = 1'b0;

        // load-use
        set_d(0, 0, 8, 5'b00000, 2, 0); settle(); tick();
        set_d(8, 0, 9, 5'b00010, 1, 0); settle();
        check("lu_stall1", stall, 1); tick();
        settle(); check("lu_stall2", stall, 0); tick();
        set_d(0, 0, 0, 5'b00000, 0, 0); settle();
        check("lu_fwd_rs_E", fwd_rs_E, 3); tick();

        // branch after ALU
        set_d(1, 2, 9, 5'b00011, 1, 0); settle(); tick();
        set_d(9, 0, 0, 5'b00001, 0, 0); settle();
        check("br_stall1", stall, 1); tick();
        settle();
        check("br_stall2", stall, 0);
        check("br_fwd_rs_D", fwd_rs_D, 2); tick();

        // store after load
        set_d(3, 0, 4, 5'b00010, 2, 0); settle(); tick();
        set_d(5, 4, 0, 5'b10010, 0, 0); settle();
        check("st_stall", stall, 0); tick();
        set_d(0, 0, 0, 5'b00000, 0, 0); settle(); tick();
        settle(); check("st_fwd_rt_M", fwd_rt_M, 3); tick();

        // register zero
        set_d(0, 0, 0, 5'b00000, 2, 0); settle(); tick();
        set_d(0, 0, 0, 5'b00101, 0, 0); settle();
        check("z_stall", stall, 0);
        check("z_fwd_rs_D", fwd_rs_D, 0);
        check("z_fwd_rt_D", fwd_rt_D, 0); tick();

        // xalu busy for 5 cycles
        reset = 1; set_d(0, 0, 0, 5'b00000, 0, 0); settle(); tick(); reset = 0;
        xalu_busy = 1; set_d(0, 0, 0, 5'b00000, 0, 1);
        for (int i = 0; i < 5; i++) begin
            settle(); check("xa_stall", stall, 1); tick();
        end
        xalu_busy = 0; settle();
        check("xa_drop", stall, 0);
        check("xa_cnt", stall_cnt, 5); tick();
        set_d(0, 0, 0, 5'b00000, 0, 0);

        // saturation then reset
        xalu_busy = 1; xalu_D = 1;
        for (int i = 0; i < 20; i++) begin settle(); tick(); end
        settle(); check("sat_cnt", stall_cnt, 15);
        reset = 1; xalu_busy = 0; xalu_D = 0; settle();
        check("rst_stall", stall, 0); tick(); reset = 0;
        settle(); check("rst_cnt", stall_cnt, 0); check("rst_stall2", stall, 0); tick();

        // reset mid-stall discards the hazard
        set_d(0, 0, 8, 5'b00000, 2, 0); settle(); tick();
        set_d(8, 0, 0, 5'b00001, 0, 0); settle();
        check("ms_stall", stall, 1);
        reset = 1; settle(); check("ms_rst_stall", stall, 0); tick(); reset = 0;
        settle(); check("ms_after", stall, 0); tick();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            reset = ($urandom_range(0, 29) == 0);
            set_d($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                  5'($urandom_range(0, 31)), $urandom_range(0, 2),
                  ($urandom_range(0, 3) == 0));
            xalu_busy = ($urandom_range(0, 3) == 0);
            settle();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
